// File: rtl/fetch_aligner.sv
// rtl/fetch_aligner.sv - halfword fetch buffer aligning 16/32-bit instructions (optional macro FETCH_ALIGNER_ILLEGAL_DET_EN)
module fetch_aligner #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             mem_req_valid,
    output logic [WIDTH-1:0] mem_req_addr,
    input  logic             mem_req_ready,
    input  logic             mem_rsp_valid,
    input  logic [31:0]      mem_rsp_data,
    output logic             ins_valid,
    input  logic             ins_ready,
    output logic [31:0]      ins,
    output logic [WIDTH-1:0] ins_pc,
    output logic             ins_compressed,
    output logic             ins_illegal
);

    // Buffer holds up to three halfwords, oldest in [15:0]; slots above hcnt stay zero.
    logic [1:0]       hcnt_q, hcnt_d;
    logic [47:0]      buf_q, buf_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] faddr_q, faddr_d;
    logic             pend_q, pend_d;
    logic             drop_q, drop_d;
    logic             skip_q, skip_d;
    logic             init_q, init_d;

    logic [15:0]      hw0;
    logic             comp;
    logic             avail;
    logic             xfer;
    logic             req_fire;
    logic             rsp_take;
    logic [1:0]       consumed;
    logic [1:0]       remain;
    logic [1:0]       added;
    logic [31:0]      new_data;
    logic [47:0]      shifted;
    logic [47:0]      placed;

    // Only halfword alignment matters for the PC; bit 0 is deliberately dropped.
    logic             unused_redirect_bit;
    assign unused_redirect_bit = redirect_pc[0];

    // Present the oldest instruction and decide request/handshake events for this cycle.
    always_comb begin
        hw0            = buf_q[15:0];
        comp           = (hw0[1:0] != 2'b11);
        avail          = (hcnt_q >= 2'd2) || ((hcnt_q == 2'd1) && comp);
        ins_valid      = !rst && avail;
        ins_compressed = ins_valid && comp;
        ins            = '0;
        if (ins_valid) begin
            ins = comp ? {16'h0000, hw0} : buf_q[31:0];
        end
        ins_pc         = pc_q;
        // init_q keeps the request quiet for the cycle following reset.
        mem_req_valid  = !rst && !init_q && !pend_q && (hcnt_q <= 2'd1) && !redirect;
        mem_req_addr   = faddr_q;
        xfer           = ins_valid && ins_ready;
        req_fire       = mem_req_valid && mem_req_ready;
        rsp_take       = mem_rsp_valid && pend_q && !drop_q;
    end

`ifdef FETCH_ALIGNER_ILLEGAL_DET_EN
    // Flag all-zero compressed and all-zero/all-one 32-bit encodings.
    always_comb begin
        ins_illegal = 1'b0;
        if (ins_valid) begin
            if (comp) begin
                ins_illegal = (hw0 == 16'h0000);
            end else begin
                ins_illegal = (buf_q[31:0] == 32'h0000_0000) || (buf_q[31:0] == 32'hFFFF_FFFF);
            end
        end
    end
`else
    assign ins_illegal = 1'b0;
`endif

    // Next buffer state: drop consumed halfwords, append response halfwords behind the survivors.
    always_comb begin
        consumed = 2'd0;
        if (xfer) begin
            consumed = comp ? 2'd1 : 2'd2;
        end
        remain = hcnt_q - consumed;

        case (consumed)
            2'd1:    shifted = {16'h0000, buf_q[47:16]};
            2'd2:    shifted = {32'h0000_0000, buf_q[47:32]};
            default: shifted = buf_q;
        endcase

        added    = 2'd0;
        new_data = '0;
        if (rsp_take) begin
            // After a redirect to an odd halfword the first word contributes only its upper half.
            added    = skip_q ? 2'd1 : 2'd2;
            new_data = skip_q ? {16'h0000, mem_rsp_data[31:16]} : mem_rsp_data;
        end
        placed = {16'h0000, new_data} << {remain, 4'b0000};

        hcnt_d  = remain + added;
        buf_d   = shifted | placed;
        pc_d    = pc_q;
        if (xfer) begin
            pc_d = pc_q + (comp ? WIDTH'(2) : WIDTH'(4));
        end
        faddr_d = req_fire ? (faddr_q + WIDTH'(4)) : faddr_q;

        pend_d  = pend_q;
        drop_d  = drop_q;
        if (req_fire) begin
            pend_d = 1'b1;
        end else if (mem_rsp_valid && pend_q) begin
            pend_d = 1'b0;
            drop_d = 1'b0;
        end
        skip_d  = rsp_take ? 1'b0 : skip_q;
        init_d  = 1'b0;

        if (redirect) begin
            hcnt_d  = 2'd0;
            buf_d   = '0;
            pc_d    = {redirect_pc[WIDTH-1:1], 1'b0};
            faddr_d = {redirect_pc[WIDTH-1:2], 2'b00};
            skip_d  = redirect_pc[1];
            // A request still in flight must be swallowed when its data finally returns.
            if (pend_q && !mem_rsp_valid) begin
                pend_d = 1'b1;
                drop_d = 1'b1;
            end else begin
                pend_d = 1'b0;
                drop_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q  <= 2'd0;
            buf_q   <= '0;
            pc_q    <= RESET_PC;
            faddr_q <= {RESET_PC[WIDTH-1:2], 2'b00};
            pend_q  <= 1'b0;
            drop_q  <= 1'b0;
            skip_q  <= RESET_PC[1];
            init_q  <= 1'b1;
        end else begin
            hcnt_q  <= hcnt_d;
            buf_q   <= buf_d;
            pc_q    <= pc_d;
            faddr_q <= faddr_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            skip_q  <= skip_d;
            init_q  <= init_d;
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// tb/tb_fetch_aligner.sv - randomized self-checking bench for fetch_aligner
module tb_fetch_aligner;

    typedef struct {
        logic [31:0] i;
        logic [31:0] pc;
        logic        c;
        logic        ill;
    } rx_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_compressed;
    logic        ins_illegal;

    int vectors = 0;
    int miscompares = 0;

    int rdy_pct = 100;
    int mreq_pct = 100;
    int lat_min = 1;
    int lat_max = 1;

    logic        m_pend = 1'b0;
    logic [31:0] m_addr = '0;
    int          m_cnt = 0;

    logic [31:0] exp_pc = '0;
    logic [31:0] exp_faddr = '0;
    logic        held = 1'b0;
    logic [31:0] h_ins, h_pc;
    logic        h_comp;
    logic        prev_rst = 1'b0;

    rx_t         rx[$];
    logic [31:0] req_log[$];
    logic [31:0] ovr[logic [31:0]];

    always #5 clk = ~clk;

    fetch_aligner #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins), .ins_pc(ins_pc),
        .ins_compressed(ins_compressed), .ins_illegal(ins_illegal)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (ovr.exists(wa)) return ovr[wa];
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_3C3C ^ (wa >> 7);
    endfunction

    function automatic logic [15:0] mem_half(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic check_cycle(input logic do_rst, input logic do_redir, input logic [31:0] rpc);
        logic [15:0] h0;
        logic        e_comp, e_ill;
        logic [31:0] e_ins;
        if (held && !do_rst && !do_redir) begin
            vectors++;
            if (ins_valid !== 1'b1 || ins !== h_ins || ins_pc !== h_pc || ins_compressed !== h_comp) begin
                miscompares++;
                $display("FAIL stable: got v=%b ins=%h pc=%h c=%b, required v=1 ins=%h pc=%h c=%b",
                         ins_valid, ins, ins_pc, ins_compressed, h_ins, h_pc, h_comp);
            end
        end
        held = 1'b0;
        if (do_rst) begin
            vectors++;
            if ({mem_req_valid, ins_valid, ins, ins_compressed, ins_illegal} !== 36'h0) begin
                miscompares++;
                $display("FAIL in_reset: got req=%b v=%b ins=%h c=%b ill=%b, required all 0",
                         mem_req_valid, ins_valid, ins, ins_compressed, ins_illegal);
            end
            exp_pc = 32'h0; exp_faddr = 32'h0; m_pend = 1'b0; prev_rst = 1'b1;
            return;
        end
        if (prev_rst) begin
            vectors++;
            if ({mem_req_valid, ins_valid, ins, ins_compressed, ins_illegal} !== 36'h0) begin
                miscompares++;
                $display("FAIL after_reset: got req=%b v=%b ins=%h c=%b ill=%b, required all 0",
                         mem_req_valid, ins_valid, ins, ins_compressed, ins_illegal);
            end
        end
        prev_rst = 1'b0;
        if (mem_rsp_valid) m_pend = 1'b0;
        else if (m_pend && m_cnt > 0) m_cnt--;
        if (do_redir) begin
            vectors++;
            if (mem_req_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL redirect_req: got %b required 0", mem_req_valid);
            end
            exp_pc = {rpc[31:1], 1'b0};
            exp_faddr = {rpc[31:2], 2'b00};
            return;
        end
        if (mem_req_valid && mem_req_ready) begin
            vectors++;
            if (m_pend || mem_req_addr !== exp_faddr) begin
                miscompares++;
                $display("FAIL req: got addr=%h pend=%b, required addr=%h pend=0", mem_req_addr, m_pend, exp_faddr);
            end
            req_log.push_back(mem_req_addr);
            m_pend = 1'b1;
            m_addr = mem_req_addr;
            m_cnt = $urandom_range(lat_max - 1, lat_min - 1);
            exp_faddr = exp_faddr + 32'd4;
        end
        if (ins_valid) begin
            if (ins_ready) begin
                h0 = mem_half(exp_pc);
                e_comp = (h0[1:0] != 2'b11);
                e_ins = e_comp ? {16'h0, h0} : {mem_half(exp_pc + 32'd2), h0};
`ifdef FETCH_ALIGNER_ILLEGAL_DET_EN
                e_ill = e_comp ? (h0 == 16'h0) : (e_ins == 32'h0 || e_ins == 32'hFFFF_FFFF);
`else
                e_ill = 1'b0;
`endif
                vectors++;
                if (ins !== e_ins || ins_compressed !== e_comp) begin
                    miscompares++;
                    $display("FAIL ins: got %h c=%b, required %h c=%b (pc %h)", ins, ins_compressed, e_ins, e_comp, exp_pc);
                end
                vectors++;
                if (ins_pc !== exp_pc) begin
                    miscompares++;
                    $display("FAIL ins_pc: got %h required %h", ins_pc, exp_pc);
                end
                vectors++;
                if (ins_illegal !== e_ill) begin
                    miscompares++;
                    $display("FAIL illegal: got %b required %b", ins_illegal, e_ill);
                end
                rx.push_back('{i: ins, pc: ins_pc, c: ins_compressed, ill: ins_illegal});
                exp_pc = exp_pc + (e_comp ? 32'd2 : 32'd4);
            end else begin
                held = 1'b1; h_ins = ins; h_pc = ins_pc; h_comp = ins_compressed;
            end
        end
    endtask

    task automatic cycle(input logic do_rst, input logic do_redir, input logic [31:0] rpc);
        @(posedge clk); #1;
        rst = do_rst;
        redirect = do_redir;
        redirect_pc = rpc;
        mem_req_ready = ($urandom_range(99) < mreq_pct);
        ins_ready = !do_redir && !do_rst && ($urandom_range(99) < rdy_pct);
        if (m_pend && m_cnt == 0) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = mem_word(m_addr);
        end else begin
            mem_rsp_valid = 1'b0; mem_rsp_data = $urandom;
        end
        @(negedge clk);
        check_cycle(do_rst, do_redir, rpc);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        rx.delete();
        req_log.delete();
    endtask

    task automatic run_until(input int n, input int budget);
        int c = 0;
        while (rx.size() < n && c < budget) begin
            cycle(1'b0, 1'b0, 32'h0);
            c++;
        end
        vectors++;
        if (rx.size() < n) begin
            miscompares++;
            $display("FAIL timeout: got %0d instructions, required %0d", rx.size(), n);
        end
    endtask

    task automatic set_knobs(input int r, input int m, input int lmin, input int lmax);
        rdy_pct = r; mreq_pct = m; lat_min = lmin; lat_max = lmax;
    endtask

    task automatic test_reset();
        ovr.delete();
        set_knobs(100, 100, 1, 1);
        do_reset();
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        vectors++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL first_req: got v=%b addr=%h, required v=1 addr=0", mem_req_valid, mem_req_addr);
        end
        run_until(4, 100);
    endtask

    task automatic test_compressed_pair();
        ovr.delete();
        ovr[32'h0] = 32'h0001_4501;
        set_knobs(100, 100, 1, 1);
        do_reset();
        run_until(2, 50);
        vectors++;
        if (rx.size() < 2 || rx[0].i !== 32'h4501 || rx[0].pc !== 32'h0 || rx[0].c !== 1'b1 ||
            rx[1].i !== 32'h0001 || rx[1].pc !== 32'h2 || rx[1].c !== 1'b1) begin
            miscompares++;
            $display("FAIL compressed_pair: got %0d entries, required 4501@0 and 0001@2 compressed", rx.size());
        end
    endtask

    task automatic test_spanning();
        ovr.delete();
        ovr[32'h0] = 32'h0513_0001;
        ovr[32'h4] = 32'h0000_0050;
        set_knobs(100, 100, 2, 3);
        do_reset();
        run_until(2, 60);
        vectors++;
        if (rx.size() < 2 || rx[0].i !== 32'h0001 || rx[0].pc !== 32'h0 ||
            rx[1].i !== 32'h0050_0513 || rx[1].pc !== 32'h2 || rx[1].c !== 1'b0) begin
            miscompares++;
            $display("FAIL spanning: got %0d entries, required 0001@0 then 00500513@2 c=0", rx.size());
        end
    endtask

    task automatic test_latency();
        int first = 0;
        ovr.delete();
        set_knobs(0, 100, 1, 1);
        do_reset();
        cycle(1'b0, 1'b1, 32'h0000_0040);
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (k == 1) begin
                vectors++;
                if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h40) begin
                    miscompares++;
                    $display("FAIL latency_req: got v=%b addr=%h, required v=1 addr=40", mem_req_valid, mem_req_addr);
                end
            end
            if (ins_valid === 1'b1 && first == 0) first = k;
        end
        vectors++;
        if (first != 3) begin
            miscompares++;
            $display("FAIL latency: got first valid at +%0d, required +3", first);
        end
        rdy_pct = 100;
        run_until(4, 60);
    endtask

    task automatic test_redirect_stale();
        int c = 0;
        ovr.delete();
        ovr[32'h100] = 32'h0001_4501;
        set_knobs(0, 100, 4, 4);
        do_reset();
        while (!m_pend && c < 20) begin
            cycle(1'b0, 1'b0, 32'h0);
            c++;
        end
        cycle(1'b0, 1'b1, 32'h0000_0102);
        req_log.delete();
        rx.delete();
        rdy_pct = 100;
        run_until(3, 100);
        vectors++;
        if (req_log.size() < 1 || req_log[0] !== 32'h100) begin
            miscompares++;
            $display("FAIL stale_addr: got %0d requests first=%h, required first=100",
                     req_log.size(), (req_log.size() > 0) ? req_log[0] : 32'hx);
        end
        vectors++;
        if (rx.size() < 1 || rx[0].i !== 32'h0001 || rx[0].pc !== 32'h102 || rx[0].c !== 1'b1) begin
            miscompares++;
            $display("FAIL stale_first: got %0d entries, required 0001@102 compressed", rx.size());
        end
    endtask

    task automatic test_stall();
        ovr.delete();
        set_knobs(0, 100, 1, 1);
        do_reset();
        for (int k = 0; k < 12; k++) cycle(1'b0, 1'b0, 32'h0);
        vectors++;
        if (mem_req_valid !== 1'b0 || m_pend !== 1'b0 || ins_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall: got req=%b pend=%b v=%b, required req=0 pend=0 v=1", mem_req_valid, m_pend, ins_valid);
        end
        rdy_pct = 100;
        run_until(20, 200);
    endtask

    task automatic test_illegal();
        logic e_ill;
        ovr.delete();
        ovr[32'h0] = 32'h0000_0000;
        set_knobs(100, 100, 1, 1);
        do_reset();
        run_until(1, 40);
`ifdef FETCH_ALIGNER_ILLEGAL_DET_EN
        e_ill = 1'b1;
`else
        e_ill = 1'b0;
`endif
        vectors++;
        if (rx.size() < 1 || rx[0].i !== 32'h0 || rx[0].c !== 1'b1 || rx[0].ill !== e_ill) begin
            miscompares++;
            $display("FAIL illegal_zero: got %0d entries, required 0000 c=1 ill=%b", rx.size(), e_ill);
        end
    endtask

    task automatic test_wrap();
        ovr.delete();
        set_knobs(100, 100, 1, 1);
        do_reset();
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
        req_log.delete();
        rx.delete();
        run_until(3, 100);
        vectors++;
        if (req_log.size() < 2 || req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap: got %0d requests, required FFFFFFFC then 00000000", req_log.size());
        end
    endtask

    task automatic test_random();
        int total = 0;
        ovr.delete();
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (k % 100 == 0) set_knobs($urandom_range(100, 30), $urandom_range(100, 30), 1, $urandom_range(5, 1));
            if ($urandom_range(999) < 3) begin
                total += rx.size();
                do_reset();
            end else if ($urandom_range(99) < 2) begin
                cycle(1'b0, 1'b1, ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hE))
                                                           : ($urandom & 32'h0000_03FE));
            end else begin
                cycle(1'b0, 1'b0, 32'h0);
            end
        end
        total += rx.size();
        vectors++;
        if (total < 300) begin
            miscompares++;
            $display("FAIL random_progress: got %0d instructions, required at least 300", total);
        end
    endtask

    initial begin
        test_reset();
        test_compressed_pair();
        test_spanning();
        test_latency();
        test_redirect_stale();
        test_stall();
        test_illegal();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_aligner.md
FETCH_ALIGNER -- requirements
Module: fetch_aligner

Interface
REQ-001 Parameter WIDTH, default 32, address width of all PC/address ports.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch PC after reset (halfword aligned).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 redirect  in  1  flush and restart fetch at redirect_pc (branch/jump, pc+imm path).
REQ-006 redirect_pc  in  WIDTH  new PC; bit 0 ignored.
REQ-007 mem_req_valid  out  1  instruction-memory read request.
REQ-008 mem_req_addr  out  WIDTH  word-aligned read address, bits [1:0] always 0.
REQ-009 mem_req_ready  in  1  memory accepts request this cycle.
REQ-010 mem_rsp_valid  in  1  read data valid.
REQ-011 mem_rsp_data  in  32  little-endian word; halfword 0 = bits [15:0].
REQ-012 ins_valid  out  1  aligned instruction available.
REQ-013 ins_ready  in  1  consumer (PC/decode stage) accepts instruction.
REQ-014 ins  out  32  instruction; compressed: {16'h0, halfword}.
REQ-015 ins_pc  out  WIDTH  PC of ins.
REQ-016 ins_compressed  out  1  1 = 16-bit instruction (consumer selects pc+2), 0 = 32-bit (pc+4).
REQ-017 ins_illegal  out  1  illegal-encoding flag (see Configuration).

Function
REQ-018 Buffer SHALL hold 0..3 halfwords (count hcnt) plus ins_pc of oldest halfword.
REQ-019 Oldest halfword with bits [1:0] != 2'b11 SHALL be treated as compressed; otherwise 32-bit, needing two halfwords.
REQ-020 ins_valid SHALL be 1 iff hcnt>=1 and oldest compressed, or hcnt>=2; combinational from buffer state.
REQ-021 Handshake: transfer when ins_valid && ins_ready; ins, ins_pc, ins_compressed SHALL stay stable while ins_valid && !ins_ready.
REQ-022 On transfer, hcnt decrements by 1 (compressed) or 2 (32-bit); ins_pc advances by 2 or 4.
REQ-023 At most one request outstanding; mem_req_valid SHALL assert when hcnt<=1, no request outstanding, and no redirect this cycle.
REQ-024 Request accepted when mem_req_valid && mem_req_ready; fetch address then advances by 4 (wraps modulo 2^WIDTH).
REQ-025 Response adds 2 halfwords (1 if first word after redirect with redirect_pc[1]=1, upper halfword only); hcnt SHALL never exceed 3.
REQ-026 Response and transfer in same cycle SHALL both apply: hcnt_next = hcnt - consumed + added.
REQ-027 32-bit instruction spanning two words SHALL be emitted only after both halfwords are buffered; ins_pc is PC of lower halfword.
REQ-028 redirect SHALL clear buffer (hcnt=0), set ins_pc to {redirect_pc[WIDTH-1:1],1'b0}, fetch address to {redirect_pc[WIDTH-1:2],2'b00}; takes priority over same-cycle transfer and response.
REQ-029 A response for a request outstanding at redirect SHALL be discarded (drop flag set until that response arrives); new request issues the cycle after the stale response or after redirect if none outstanding.
REQ-030 Minimum latency: redirect at cycle N, request at N+1, response at N+k -> ins_valid at N+k+1.

Reset
REQ-031 On rst: hcnt=0, no outstanding request, drop flag 0, ins_pc=RESET_PC, fetch address={RESET_PC[WIDTH-1:2],2'b00}, half-skip = RESET_PC[1].
REQ-032 During and cycle after rst: mem_req_valid=0, ins_valid=0, ins=0, ins_compressed=0, ins_illegal=0.
REQ-033 rst SHALL override redirect and any in-flight response; a response arriving after rst for a pre-reset request SHALL be discarded.

Configuration
REQ-034 Macro FETCH_ALIGNER_ILLEGAL_DET_EN defined: ins_illegal=1 when emitted instruction is compressed halfword 16'h0000 or 32-bit word 32'h0000_0000 or 32'hFFFF_FFFF.
REQ-035 Macro undefined: ins_illegal tied to 0, no detection logic.

Verification
REQ-036 Reset, RESET_PC=0, memory returns 32'h0001_4501 (two compressed) -> ins 16'h4501 pc 0, then 16'h0001 pc 2, ins_compressed=1 both.
REQ-037 Words 32'h0513_0001 then 32'h0000_0050 -> ins 16'h0001 pc 0, then 32'h0050_0513 pc 2 compressed=0.
REQ-038 redirect_pc=32'h0000_0102 while response outstanding -> stale data dropped, request addr 0x100, first ins_pc 0x102 from upper halfword.
REQ-039 ins_ready=0 for 5 cycles with ins_valid=1 -> outputs stable, mem_req_valid=0 once hcnt>=2, no data lost.
REQ-040 Macro defined, memory returns 32'h0000_0000 at pc 0 -> ins_illegal=1, compressed=1; macro undefined -> ins_illegal=0.
REQ-041 Fetch address 32'hFFFF_FFFC accepted -> next mem_req_addr 32'h0000_0000.
